// File: rtl/inst_loader_if.sv
// Handshake and memory-write bundle for the serial instruction loader.
// The master side is the program source and observer; the loader is the slave.
interface inst_loader_if #(
    parameter int INST_W = 19,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
);
    logic              start;
    logic [LEN_W-1:0]  load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  words_loaded;

    modport master (
        output start, load_len, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold,
               done, error, words_loaded
    );

    modport slave (
        input  start, load_len, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold,
               done, error, words_loaded
    );
endinterface

// File: rtl/inst_loader.sv
// Serial instruction loader: assembles three big-endian bytes per word and
// writes them into instruction memory while holding the CPU.
//   state | meaning
//   IDLE  | waiting for start; words_loaded/error hold last load's result
//   B0    | waiting for byte 0 (bits 18:16, upper five bits must be zero)
//   B1    | waiting for byte 1 (bits 15:8)
//   B2    | waiting for byte 2 (bits 7:0)
//   WRITE | one-cycle memory write of the assembled word
//   FIN   | one-cycle done pulse, then back to IDLE
module inst_loader #(
    parameter int INST_W = 19,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic          clk,
    input  logic          reset,
    inst_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, FIN} state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              err_q, err_d;
    logic [2:0]        hi_q, hi_d;
    logic [7:0]        mid_q, mid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] wdata_q, wdata_d;
    logic              ready;
    logic              accept;

    assign ready  = (state_q == B0) || (state_q == B1) || (state_q == B2);
    assign accept = ready && bus.byte_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            mid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
            mid_q   <= mid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        err_d   = err_q;
        hi_d    = hi_q;
        mid_d   = mid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Clamping to DEPTH keeps the write address from wrapping.
                    len_d   = (bus.load_len > DEPTH_L) ? DEPTH_L : bus.load_len;
                    words_d = '0;
                    err_d   = 1'b0;
                    state_d = (bus.load_len == '0) ? FIN : B0;
                end
            end
            B0: begin
                if (accept) begin
                    if (|bus.byte_in[7:3]) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        hi_d    = bus.byte_in[2:0];
                        state_d = B1;
                    end
                end
            end
            B1: begin
                if (accept) begin
                    mid_d   = bus.byte_in;
                    state_d = B2;
                end
            end
            B2: begin
                if (accept) begin
                    // Address and data registers change only here, so they hold
                    // steady whenever mem_we is low.
                    wdata_d = INST_W'({hi_q, mid_q, bus.byte_in});
                    addr_d  = words_q[ADDR_W-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_q + LEN_W'(1);
                state_d = (words_d == len_q) ? FIN : B0;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.byte_ready   = ready;
    assign bus.mem_we       = (state_q == WRITE);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.cpu_hold     = (state_q != IDLE);
    assign bus.done         = (state_q == FIN);
    assign bus.error        = err_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a posedge monitor records memory writes,
// done pulses and busy cycles; each scenario task checks against fixed values.
module tb_inst_loader;
    logic clk;
    logic reset;

    inst_loader_if #(.INST_W(19), .ADDR_W(8), .LEN_W(9)) bus ();

    inst_loader #(.INST_W(19), .DEPTH(256), .ADDR_W(8), .LEN_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [18:0] mem_model [256];
    int wr_count   = 0;
    int done_count = 0;
    int busy_count = 0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_model[bus.mem_addr] = bus.mem_wdata;
            wr_count = wr_count + 1;
        end
        if (bus.done) done_count = done_count + 1;
        if (bus.busy) busy_count = busy_count + 1;
    end

    function automatic logic [18:0] word_of(input int i);
        return 19'((i * 313 + 7) & 32'h7FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic pulse_start(input logic [8:0] len);
        bus.start    = 1'b1;
        bus.load_len = len;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.load_len = 9'h1FF;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= 50) $display("FAIL byte_ready_timeout: waited %0d cycles, limit 50", n);
        else n_pass++;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [18:0] w, input int gapmax);
        send_byte({5'b0, w[18:16]}, int'($urandom_range(gapmax, 0)));
        send_byte(w[15:8], int'($urandom_range(gapmax, 0)));
        send_byte(w[7:0], int'($urandom_range(gapmax, 0)));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= 40) $display("FAIL %s_done_timeout: waited %0d cycles, limit 40", name, n);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.load_len = '0;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        #1;
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_words_loaded", 32'(bus.words_loaded), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_two_word;
        int wr0, dn0;
        wr0 = wr_count;
        dn0 = done_count;
        pulse_start(9'd2);
        chk("two_busy", 32'(bus.busy), 32'd1);
        chk("two_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'h05, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'h00, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        wait_done("two");
        chk("two_writes", 32'(wr_count - wr0), 32'd2);
        chk("two_mem0", 32'(mem_model[0]), 32'h5ABCD);
        chk("two_mem1", 32'(mem_model[1]), 32'h01234);
        chk("two_done_count", 32'(done_count - dn0), 32'd1);
        chk("two_words_loaded", 32'(bus.words_loaded), 32'd2);
        chk("two_error", 32'(bus.error), 32'd0);
        chk("two_busy_after", 32'(bus.busy), 32'd0);
        chk("two_addr_hold", 32'(bus.mem_addr), 32'd1);
        chk("two_wdata_hold", 32'(bus.mem_wdata), 32'h01234);
    endtask

    task automatic test_zero_len;
        int wr0, dn0, bz0;
        wr0 = wr_count;
        dn0 = done_count;
        bz0 = busy_count;
        pulse_start(9'd0);
        chk("zero_done_now", 32'(bus.done), 32'd1);
        repeat (4) @(negedge clk);
        chk("zero_writes", 32'(wr_count - wr0), 32'd0);
        chk("zero_done_count", 32'(done_count - dn0), 32'd1);
        chk("zero_busy_cycles", 32'(busy_count - bz0), 32'd1);
        chk("zero_words_loaded", 32'(bus.words_loaded), 32'd0);
    endtask

    task automatic test_format_error;
        int wr0, dn0;
        wr0 = wr_count;
        dn0 = done_count;
        pulse_start(9'd2);
        send_byte(8'h28, 0);
        wait_done("fmt");
        repeat (3) @(negedge clk);
        chk("fmt_error", 32'(bus.error), 32'd1);
        chk("fmt_done_count", 32'(done_count - dn0), 32'd1);
        chk("fmt_writes", 32'(wr_count - wr0), 32'd0);
        pulse_start(9'd1);
        chk("fmt_error_cleared", 32'(bus.error), 32'd0);
        send_word(19'h10203, 0);
        wait_done("fmt2");
        chk("fmt2_mem0", 32'(mem_model[0]), 32'h10203);
        chk("fmt2_error", 32'(bus.error), 32'd0);
        chk("fmt2_words_loaded", 32'(bus.words_loaded), 32'd1);
    endtask

    task automatic test_stall;
        int wr0, dn0;
        wr0 = wr_count;
        dn0 = done_count;
        mem_model[0] = '0;
        mem_model[1] = '0;
        pulse_start(9'd2);
        send_byte(8'h05, 2);
        send_byte(8'hAB, 3);
        bus.start = 1'b1;
        bus.load_len = 9'd5;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(8'hCD, int'($urandom_range(3, 0)));
        send_byte(8'h00, int'($urandom_range(3, 0)));
        send_byte(8'h12, int'($urandom_range(3, 0)));
        send_byte(8'h34, int'($urandom_range(3, 0)));
        wait_done("stall");
        chk("stall_writes", 32'(wr_count - wr0), 32'd2);
        chk("stall_mem0", 32'(mem_model[0]), 32'h5ABCD);
        chk("stall_mem1", 32'(mem_model[1]), 32'h01234);
        chk("stall_words_loaded", 32'(bus.words_loaded), 32'd2);
        chk("stall_done_count", 32'(done_count - dn0), 32'd1);
    endtask

    task automatic test_full_depth;
        int wr0, dn0, bad;
        wr0 = wr_count;
        dn0 = done_count;
        pulse_start(9'd300);
        for (int i = 0; i < 256; i++) send_word(word_of(i), 0);
        wait_done("full");
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem_model[i] !== word_of(i)) bad++;
        chk("full_writes", 32'(wr_count - wr0), 32'd256);
        chk("full_bad_words", 32'(bad), 32'd0);
        chk("full_words_loaded", 32'(bus.words_loaded), 32'd256);
        chk("full_done_count", 32'(done_count - dn0), 32'd1);
        chk("full_busy_after", 32'(bus.busy), 32'd0);
    endtask

    task automatic test_reset_mid;
        int wr0, dn0;
        pulse_start(9'd5);
        send_word(19'h11111, 0);
        send_word(19'h22222, 0);
        send_byte(8'h03, 0);
        wr0 = wr_count;
        dn0 = done_count;
        chk("mid_in_b1_ready", 32'(bus.byte_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("mid_rst_words_loaded", 32'(bus.words_loaded), 32'd0);
        chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        bus.byte_in = 8'h44;
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("mid_no_writes", 32'(wr_count - wr0), 32'd0);
        chk("mid_no_done", 32'(done_count - dn0), 32'd0);
        chk("mid_mem1_intact", 32'(mem_model[1]), 32'h22222);
        reset = 1'b0;
        pulse_start(9'd1);
        chk("mid_restart_busy", 32'(bus.busy), 32'd1);
        send_word(19'h7FFFF, 1);
        wait_done("mid");
        chk("mid_restart_mem0", 32'(mem_model[0]), 32'h7FFFF);
        chk("mid_restart_words", 32'(bus.words_loaded), 32'd1);
        chk("mid_restart_done", 32'(done_count - dn0), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        test_reset;
        test_two_word;
        test_zero_len;
        test_format_error;
        test_stall;
        test_full_depth;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
